// File: rtl/gelato_rf_arbiter_if.sv
// gelato_rf_arbiter_if
//   Collector-side bundle of the register-file arbiter. It carries the
//   request vector from the operand collector and the per-bank read
//   responses back to it.
//   master modport : operand collector (drives req_*, receives resp_*)
//   slave modport  : arbiter (receives req_*, drives resp_*)
//   req_valid        whole request vector valid
//   req_entry_valid  per collector entry valid
//   req_warp_num     per entry warp number
//   req_reg_num      per operand slot register number (slot = entry*4+operand)
//   req_reg_valid    per operand slot still waiting for data
//   resp_valid       any bank returned data this cycle
//   resp_data_valid  per bank response valid
//   resp_coll_index  per bank destination collector entry
//   resp_reg_index   per bank destination operand slot
//   resp_data        per bank read data
interface gelato_rf_arbiter_if #(
  parameter int BANK_NUM       = 4,
  parameter int COLLECTOR_SIZE = 4,
  parameter int WARP_W         = 5,
  parameter int REG_W          = 5,
  parameter int DATA_W         = 1024
);
  localparam int CI_W = (COLLECTOR_SIZE > 1) ? $clog2(COLLECTOR_SIZE) : 1;

  logic                             req_valid;
  logic [COLLECTOR_SIZE-1:0]        req_entry_valid;
  logic [COLLECTOR_SIZE*WARP_W-1:0] req_warp_num;
  logic [COLLECTOR_SIZE*4*REG_W-1:0] req_reg_num;
  logic [COLLECTOR_SIZE*4-1:0]      req_reg_valid;

  logic                             resp_valid;
  logic [BANK_NUM-1:0]              resp_data_valid;
  logic [BANK_NUM*CI_W-1:0]         resp_coll_index;
  logic [BANK_NUM*2-1:0]            resp_reg_index;
  logic [BANK_NUM*DATA_W-1:0]       resp_data;

  modport master (
    output req_valid, req_entry_valid, req_warp_num, req_reg_num, req_reg_valid,
    input  resp_valid, resp_data_valid, resp_coll_index, resp_reg_index, resp_data
  );

  modport slave (
    input  req_valid, req_entry_valid, req_warp_num, req_reg_num, req_reg_valid,
    output resp_valid, resp_data_valid, resp_coll_index, resp_reg_index, resp_data
  );
endinterface

// File: rtl/gelato_rf_arbiter.sv
// gelato_rf_arbiter
//   Arbitrates operand reads from the operand collector onto a banked
//   register file. Each cycle every bank grants at most one pending operand
//   slot (round robin over slot ids), drives the bank read address, and one
//   cycle later returns the bank data together with the registered
//   destination entry/slot. A writeback owns the bank it targets for that
//   cycle; reads on that bank wait.
//
//   Optional build macro GELATO_RF_ARB_STATS_EN adds conflict_count, a
//   saturating count of cycles with bank contention or writeback blocking.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   conflict_count    (GELATO_RF_ARB_STATS_EN only) contention cycle count
//   coll              collector request/response bundle (slave side)
//   wb_valid          writeback request
//   wb_warp_num       writeback warp
//   wb_reg_num        writeback register
//   wb_thread_mask    writeback lane mask
//   wb_data           writeback data
//   bank_reg_num      per bank register address
//   bank_warp_num     per bank warp address
//   bank_write        per bank write strobe
//   bank_thread_mask  write lane mask shared by all banks
//   bank_write_data   write data shared by all banks
//   bank_rdata        per bank read data, one cycle after the address
module gelato_rf_arbiter #(
  parameter int BANK_NUM       = 4,
  parameter int COLLECTOR_SIZE = 4,
  parameter int WARP_W         = 5,
  parameter int REG_W          = 5,
  parameter int THREADS        = 32,
  parameter int DATA_W         = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef GELATO_RF_ARB_STATS_EN
  output logic [31:0]                  conflict_count,
`endif
  gelato_rf_arbiter_if.slave           coll,
  input  logic                         wb_valid,
  input  logic [WARP_W-1:0]            wb_warp_num,
  input  logic [REG_W-1:0]             wb_reg_num,
  input  logic [THREADS-1:0]           wb_thread_mask,
  input  logic [DATA_W-1:0]            wb_data,
  output logic [BANK_NUM*REG_W-1:0]    bank_reg_num,
  output logic [BANK_NUM*WARP_W-1:0]   bank_warp_num,
  output logic [BANK_NUM-1:0]          bank_write,
  output logic [THREADS-1:0]           bank_thread_mask,
  output logic [DATA_W-1:0]            bank_write_data,
  input  logic [BANK_NUM*DATA_W-1:0]   bank_rdata
);

  localparam int SLOTS  = COLLECTOR_SIZE * 4;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int BANK_W = $clog2(BANK_NUM);
  localparam int CI_W   = (COLLECTOR_SIZE > 1) ? $clog2(COLLECTOR_SIZE) : 1;

  logic [BANK_W-1:0] slot_bank [SLOTS];
  logic [SLOTS-1:0]  eligible;
  logic [SLOTS-1:0]  inflight;
  logic [SLOTS-1:0]  read_mask;
  logic [SLOT_W-1:0] rr [BANK_NUM];
  logic [BANK_NUM-1:0] grant_valid;
  logic [SLOT_W-1:0] grant_slot [BANK_NUM];
  logic [SLOT_W-1:0] scan_idx;
  logic [BANK_W-1:0] wb_bank;

  // Bank interleave: sum taken at register width, low bits select the bank.
  function automatic logic [BANK_W-1:0] bank_of(input logic [REG_W-1:0] reg_num,
                                                input logic [WARP_W-1:0] warp_num);
    logic [REG_W-1:0] sum;
    sum = reg_num + REG_W'(warp_num);
    return sum[BANK_W-1:0];
  endfunction

  assign wb_bank = bank_of(wb_reg_num, wb_warp_num);

  // Bank of every operand slot and whether it may compete this cycle.
  // A slot already granted last cycle stays out until the collector has
  // seen its data and dropped reg_valid.
  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      slot_bank[s] = bank_of(coll.req_reg_num[s*REG_W +: REG_W],
                             coll.req_warp_num[(s/4)*WARP_W +: WARP_W]);
      eligible[s]  = coll.req_valid & coll.req_entry_valid[s/4] &
                     coll.req_reg_valid[s] & ~inflight[s];
    end
  end

  // Per-bank round robin: scan from rr[b] with wrap and take the first
  // eligible slot on this bank. The writeback bank is vetoed afterwards so
  // its pointer does not move.
  always_comb begin
    grant_valid = '0;
    read_mask   = '0;
    scan_idx    = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      grant_slot[b] = '0;
      for (int k = 0; k < SLOTS; k++) begin
        scan_idx = SLOT_W'((int'(rr[b]) + k) % SLOTS);
        if (!grant_valid[b] && eligible[scan_idx] && slot_bank[scan_idx] == BANK_W'(b)) begin
          grant_valid[b] = 1'b1;
          grant_slot[b]  = scan_idx;
        end
      end
      if (wb_valid && wb_bank == BANK_W'(b)) begin
        grant_valid[b] = 1'b0;
      end
      if (grant_valid[b]) begin
        read_mask[grant_slot[b]] = 1'b1;
      end
    end
  end

  // Bank address mux: writeback first, then the granted read, else idle 0.
  always_comb begin
    bank_reg_num  = '0;
    bank_warp_num = '0;
    bank_write    = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (wb_valid && wb_bank == BANK_W'(b)) begin
        bank_write[b]                      = rst_n;
        bank_reg_num[b*REG_W +: REG_W]     = wb_reg_num;
        bank_warp_num[b*WARP_W +: WARP_W]  = wb_warp_num;
      end else if (grant_valid[b]) begin
        bank_reg_num[b*REG_W +: REG_W]     = coll.req_reg_num[int'(grant_slot[b])*REG_W +: REG_W];
        bank_warp_num[b*WARP_W +: WARP_W]  = coll.req_warp_num[(int'(grant_slot[b])/4)*WARP_W +: WARP_W];
      end
    end
  end

  assign bank_thread_mask = wb_thread_mask;
  assign bank_write_data  = wb_data;

  // Response metadata is registered so it lines up with the synchronous
  // bank read data one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight             <= '0;
      coll.resp_data_valid <= '0;
      coll.resp_coll_index <= '0;
      coll.resp_reg_index  <= '0;
      for (int b = 0; b < BANK_NUM; b++) begin
        rr[b] <= '0;
      end
    end else begin
      inflight             <= read_mask;
      coll.resp_data_valid <= grant_valid;
      for (int b = 0; b < BANK_NUM; b++) begin
        coll.resp_coll_index[b*CI_W +: CI_W] <= CI_W'(int'(grant_slot[b]) / 4);
        coll.resp_reg_index[b*2 +: 2]        <= grant_slot[b][1:0];
        if (grant_valid[b]) begin
          rr[b] <= SLOT_W'((int'(grant_slot[b]) + 1) % SLOTS);
        end
      end
    end
  end

  assign coll.resp_valid = |coll.resp_data_valid;
  assign coll.resp_data  = bank_rdata;

`ifdef GELATO_RF_ARB_STATS_EN
  logic [BANK_NUM-1:0] bank_has_elig;
  logic [BANK_NUM-1:0] bank_multi_elig;
  logic                conflict_now;

  // A cycle counts when some bank sees two or more candidates, or when a
  // writeback displaces a pending read.
  always_comb begin
    bank_has_elig   = '0;
    bank_multi_elig = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (eligible[s] && slot_bank[s] == BANK_W'(b)) begin
          if (bank_has_elig[b]) begin
            bank_multi_elig[b] = 1'b1;
          end
          bank_has_elig[b] = 1'b1;
        end
      end
    end
    conflict_now = (|bank_multi_elig) | (wb_valid & bank_has_elig[wb_bank]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_count <= '0;
    end else if (conflict_now && conflict_count != 32'hFFFF_FFFF) begin
      conflict_count <= conflict_count + 32'd1;
    end
  end
`else
  // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_gelato_rf_arbiter.sv
// tb_gelato_rf_arbiter
//   Directed bench for gelato_rf_arbiter: a table of single-request vectors
//   followed by hand-written multi-cycle sequences (bank contention,
//   writeback priority, reset while a response is pending, pointer reset).
//   A behavioural write-first banked register file backs the bank ports.
module tb_gelato_rf_arbiter;

  localparam int BANK_NUM = 4;
  localparam int CS       = 4;
  localparam int WARP_W   = 5;
  localparam int REG_W    = 5;
  localparam int THREADS  = 32;
  localparam int DATA_W   = 1024;

  logic clk = 1'b0;
  logic rst_n;
  logic wb_valid;
  logic [WARP_W-1:0] wb_warp_num;
  logic [REG_W-1:0] wb_reg_num;
  logic [THREADS-1:0] wb_thread_mask;
  logic [DATA_W-1:0] wb_data;
  logic [BANK_NUM*REG_W-1:0] bank_reg_num;
  logic [BANK_NUM*WARP_W-1:0] bank_warp_num;
  logic [BANK_NUM-1:0] bank_write;
  logic [THREADS-1:0] bank_thread_mask;
  logic [DATA_W-1:0] bank_write_data;
  logic [BANK_NUM*DATA_W-1:0] bank_rdata = '0;
`ifdef GELATO_RF_ARB_STATS_EN
  logic [31:0] conflict_count;
`endif

  int checks = 0;
  int errors = 0;

  gelato_rf_arbiter_if #(
    .BANK_NUM(BANK_NUM), .COLLECTOR_SIZE(CS), .WARP_W(WARP_W),
    .REG_W(REG_W), .DATA_W(DATA_W)
  ) coll_if ();

  gelato_rf_arbiter #(
    .BANK_NUM(BANK_NUM), .COLLECTOR_SIZE(CS), .WARP_W(WARP_W),
    .REG_W(REG_W), .THREADS(THREADS), .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef GELATO_RF_ARB_STATS_EN
    .conflict_count(conflict_count),
`endif
    .coll(coll_if),
    .wb_valid(wb_valid),
    .wb_warp_num(wb_warp_num),
    .wb_reg_num(wb_reg_num),
    .wb_thread_mask(wb_thread_mask),
    .wb_data(wb_data),
    .bank_reg_num(bank_reg_num),
    .bank_warp_num(bank_warp_num),
    .bank_write(bank_write),
    .bank_thread_mask(bank_thread_mask),
    .bank_write_data(bank_write_data),
    .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;

  // Initial register contents are a recognisable function of warp/reg.
  function automatic logic [DATA_W-1:0] pattern(input int w, input int r);
    logic [31:0] word;
    word = 32'hC0DE0000 | 32'(w << 8) | 32'(r);
    return {32{word}};
  endfunction

  // Behavioural banked register file, write-first, one-cycle read.
  logic [DATA_W-1:0] mem [32][32];
  logic [DATA_W-1:0] wr_word;

  initial begin
    for (int w = 0; w < 32; w++)
      for (int r = 0; r < 32; r++)
        mem[w][r] = pattern(w, r);
  end

  always @(posedge clk) begin
    for (int b = 0; b < BANK_NUM; b++) begin
      if (bank_write[b]) begin
        wr_word = mem[bank_warp_num[b*WARP_W +: WARP_W]][bank_reg_num[b*REG_W +: REG_W]];
        for (int l = 0; l < THREADS; l++)
          if (bank_thread_mask[l]) wr_word[l*32 +: 32] = bank_write_data[l*32 +: 32];
        mem[bank_warp_num[b*WARP_W +: WARP_W]][bank_reg_num[b*REG_W +: REG_W]] <= wr_word;
        bank_rdata[b*DATA_W +: DATA_W] <= wr_word;
      end else begin
        bank_rdata[b*DATA_W +: DATA_W] <=
          mem[bank_warp_num[b*WARP_W +: WARP_W]][bank_reg_num[b*REG_W +: REG_W]];
      end
    end
  end

  typedef struct {
    logic [3:0]  entry_valid;
    logic [19:0] warps;
    logic [79:0] regs;
    logic [15:0] reg_valid;
    logic        wb_valid;
    logic [4:0]  wb_warp;
    logic [4:0]  wb_reg;
    logic [3:0]  exp_write;
    logic [3:0]  exp_rdv;
    logic [7:0]  exp_coll;
    logic [7:0]  exp_reg;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual[63:0]=%h expected[63:0]=%h", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic clearReq();
    coll_if.req_valid       = 1'b0;
    coll_if.req_entry_valid = '0;
    coll_if.req_warp_num    = '0;
    coll_if.req_reg_num     = '0;
    coll_if.req_reg_valid   = '0;
  endtask

  task automatic clearVec(input int i);
    vecs[i].entry_valid = '0;
    vecs[i].warps       = '0;
    vecs[i].regs        = '0;
    vecs[i].reg_valid   = '0;
    vecs[i].wb_valid    = 1'b0;
    vecs[i].wb_warp     = '0;
    vecs[i].wb_reg      = '0;
    vecs[i].exp_write   = '0;
    vecs[i].exp_rdv     = '0;
    vecs[i].exp_coll    = '0;
    vecs[i].exp_reg     = '0;
  endtask

  task automatic setSlot(input int i, input int s, input int r);
    vecs[i].regs[s*5 +: 5] = 5'(r);
    vecs[i].reg_valid[s]   = 1'b1;
  endtask

  // One request cycle, then the response cycle, then an idle cycle.
  task automatic applyStimulus(input int idx, input vec_t v);
    logic [19:0] exp_breg;
    logic [19:0] exp_bwarp;
    logic [7:0]  idx_mask;
    int c;
    int slot;
    @(negedge clk);
    coll_if.req_valid       = 1'b1;
    coll_if.req_entry_valid = v.entry_valid;
    coll_if.req_warp_num    = v.warps;
    coll_if.req_reg_num     = v.regs;
    coll_if.req_reg_valid   = v.reg_valid;
    wb_valid    = v.wb_valid;
    wb_warp_num = v.wb_warp;
    wb_reg_num  = v.wb_reg;
    #1;
    exp_breg  = '0;
    exp_bwarp = '0;
    idx_mask  = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (v.exp_write[b]) begin
        exp_breg[b*5 +: 5]  = v.wb_reg;
        exp_bwarp[b*5 +: 5] = v.wb_warp;
      end else if (v.exp_rdv[b]) begin
        c    = int'(v.exp_coll[b*2 +: 2]);
        slot = c*4 + int'(v.exp_reg[b*2 +: 2]);
        exp_breg[b*5 +: 5]  = v.regs[slot*5 +: 5];
        exp_bwarp[b*5 +: 5] = v.warps[c*5 +: 5];
        idx_mask[b*2 +: 2]  = 2'b11;
      end
    end
    checkOutput($sformatf("v%0d_bank_write", idx), 64'(bank_write), 64'(v.exp_write));
    checkOutput($sformatf("v%0d_bank_reg", idx), 64'(bank_reg_num), 64'(exp_breg));
    checkOutput($sformatf("v%0d_bank_warp", idx), 64'(bank_warp_num), 64'(exp_bwarp));
    @(posedge clk);
    #1;
    clearReq();
    wb_valid = 1'b0;
    checkOutput($sformatf("v%0d_resp_data_valid", idx), 64'(coll_if.resp_data_valid), 64'(v.exp_rdv));
    checkOutput($sformatf("v%0d_resp_valid", idx), 64'(coll_if.resp_valid), 64'(|v.exp_rdv));
    checkOutput($sformatf("v%0d_coll_index", idx), 64'(coll_if.resp_coll_index & idx_mask),
                64'(v.exp_coll & idx_mask));
    checkOutput($sformatf("v%0d_reg_index", idx), 64'(coll_if.resp_reg_index & idx_mask),
                64'(v.exp_reg & idx_mask));
    for (int b = 0; b < BANK_NUM; b++) begin
      if (v.exp_rdv[b]) begin
        checkData($sformatf("v%0d_data_b%0d", idx, b), coll_if.resp_data[b*DATA_W +: DATA_W],
                  pattern(int'(exp_bwarp[b*5 +: 5]), int'(exp_breg[b*5 +: 5])));
      end
    end
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d_idle_rdv", idx), 64'(coll_if.resp_data_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Table: each vector keeps at most one candidate per bank.
    for (int i = 0; i < NVEC; i++) clearVec(i);
    // v0: coll0 slot0 warp2 reg5 -> bank3
    vecs[0].entry_valid = 4'b0001; vecs[0].warps[4:0] = 5'd2; setSlot(0, 0, 5);
    vecs[0].exp_rdv = 4'b1000;
    // v1: coll0 warp0 regs 0..3 -> all four banks at once
    vecs[1].entry_valid = 4'b0001;
    for (int o = 0; o < 4; o++) setSlot(1, o, o);
    vecs[1].exp_rdv = 4'b1111; vecs[1].exp_reg = 8'b11_10_01_00;
    // v2: coll2 slot1 warp1 reg0 -> bank1, coll3 slot3 warp3 reg0 -> bank3
    vecs[2].entry_valid = 4'b1100; vecs[2].warps[14:10] = 5'd1; vecs[2].warps[19:15] = 5'd3;
    setSlot(2, 9, 0); setSlot(2, 15, 0);
    vecs[2].exp_rdv = 4'b1010; vecs[2].exp_coll = 8'b11_00_10_00; vecs[2].exp_reg = 8'b11_00_01_00;
    // v3: entry valid but no operand still needed -> nothing
    vecs[3].entry_valid = 4'b0010; vecs[3].warps[9:5] = 5'd4;
    for (int o = 0; o < 4; o++) vecs[3].regs[(4+o)*5 +: 5] = 5'(o + 1);
    // v4: slot of an invalid entry ignored; coll1 slot2 warp0 reg2 -> bank2
    vecs[4].entry_valid = 4'b0010; setSlot(4, 0, 0); setSlot(4, 6, 2);
    vecs[4].exp_rdv = 4'b0100; vecs[4].exp_coll = 8'b00_01_00_00; vecs[4].exp_reg = 8'b00_10_00_00;
    // v5: writeback to bank0 alongside a read on bank2
    vecs[5].entry_valid = 4'b0001; vecs[5].warps[4:0] = 5'd1; setSlot(5, 0, 1);
    vecs[5].wb_valid = 1'b1; vecs[5].wb_warp = 5'd0; vecs[5].wb_reg = 5'd0;
    vecs[5].exp_write = 4'b0001; vecs[5].exp_rdv = 4'b0100;
    // v6: writeback only, warp3 reg2 -> bank1
    vecs[6].wb_valid = 1'b1; vecs[6].wb_warp = 5'd3; vecs[6].wb_reg = 5'd2;
    vecs[6].exp_write = 4'b0010;

    clearReq();
    wb_thread_mask = '1;
    wb_data        = {32{32'h5A5A0001}};
    wb_warp_num    = '0;
    wb_reg_num     = '0;
    wb_valid       = 1'b1;
    rst_n          = 1'b0;
    #12;
    checkOutput("reset_bank_write", 64'(bank_write), 64'd0);
    checkOutput("reset_resp_data_valid", 64'(coll_if.resp_data_valid), 64'd0);
    checkOutput("reset_resp_valid", 64'(coll_if.resp_valid), 64'd0);
`ifdef GELATO_RF_ARB_STATS_EN
    checkOutput("reset_conflict_count", 64'(conflict_count), 64'd0);
`endif
    wb_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) applyStimulus(i, vecs[i]);

    // Two collectors on the same register/bank: served on consecutive cycles.
    $display("[TB] sequence: bank contention");
    @(negedge clk);
    coll_if.req_valid = 1'b1; coll_if.req_entry_valid = 4'b0011;
    coll_if.req_reg_num[0*5 +: 5] = 5'd1; coll_if.req_reg_num[4*5 +: 5] = 5'd1;
    coll_if.req_reg_valid = 16'h0011;
    @(posedge clk); #1;
    checkOutput("contend_first_rdv", 64'(coll_if.resp_data_valid), 64'b0010);
    checkOutput("contend_first_coll", 64'(coll_if.resp_coll_index[3:2]), 64'd0);
    checkData("contend_first_data", coll_if.resp_data[1*DATA_W +: DATA_W], pattern(0, 1));
    coll_if.req_reg_valid[0] = 1'b0;
    @(posedge clk); #1;
    checkOutput("contend_second_rdv", 64'(coll_if.resp_data_valid), 64'b0010);
    checkOutput("contend_second_coll", 64'(coll_if.resp_coll_index[3:2]), 64'd1);
    clearReq();
    @(posedge clk); #1;
    checkOutput("contend_idle_rdv", 64'(coll_if.resp_data_valid), 64'd0);
`ifdef GELATO_RF_ARB_STATS_EN
    checkOutput("contend_conflict_count", 64'(conflict_count), 64'd1);
`endif

    // Writeback and read of the same register in the same cycle.
    $display("[TB] sequence: writeback priority");
    @(negedge clk);
    coll_if.req_valid = 1'b1; coll_if.req_entry_valid = 4'b0001;
    coll_if.req_reg_num[4:0] = 5'd3; coll_if.req_reg_valid = 16'h0001;
    wb_valid = 1'b1; wb_warp_num = 5'd0; wb_reg_num = 5'd3; wb_data = {128{8'hA5}};
    #1;
    checkOutput("wb_bank_write", 64'(bank_write), 64'b1000);
    checkOutput("wb_bank3_reg", 64'(bank_reg_num[15 +: 5]), 64'd3);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    checkOutput("wb_blocked_rdv", 64'(coll_if.resp_data_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("wb_read_rdv", 64'(coll_if.resp_data_valid), 64'b1000);
    checkOutput("wb_read_coll", 64'(coll_if.resp_coll_index[7:6]), 64'd0);
    checkData("wb_read_data", coll_if.resp_data[3*DATA_W +: DATA_W], {128{8'hA5}});
    clearReq();
    @(posedge clk); #1;
    checkOutput("wb_idle_rdv", 64'(coll_if.resp_data_valid), 64'd0);
`ifdef GELATO_RF_ARB_STATS_EN
    checkOutput("wb_conflict_count", 64'(conflict_count), 64'd2);
`endif

    // Reset while a response is outstanding.
    $display("[TB] sequence: reset with pending response");
    @(negedge clk);
    coll_if.req_valid = 1'b1; coll_if.req_entry_valid = 4'b0001;
    coll_if.req_warp_num[4:0] = 5'd2; coll_if.req_reg_num[4:0] = 5'd5;
    coll_if.req_reg_valid = 16'h0001;
    @(posedge clk); #1;
    checkOutput("rst_pre_rdv", 64'(coll_if.resp_data_valid), 64'b1000);
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_warp_num = 5'd1; wb_reg_num = 5'd0;
    #1;
    checkOutput("rst_drop_rdv", 64'(coll_if.resp_data_valid), 64'd0);
    checkOutput("rst_drop_resp_valid", 64'(coll_if.resp_valid), 64'd0);
    checkOutput("rst_bank_write", 64'(bank_write), 64'd0);
`ifdef GELATO_RF_ARB_STATS_EN
    checkOutput("rst_conflict_count", 64'(conflict_count), 64'd0);
`endif
    clearReq();
    wb_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("rst_quiet_rdv_%0d", i), 64'(coll_if.resp_data_valid), 64'd0);
    end
    @(negedge clk);
    coll_if.req_valid = 1'b1; coll_if.req_entry_valid = 4'b0001;
    coll_if.req_warp_num[4:0] = 5'd2; coll_if.req_reg_num[4:0] = 5'd5;
    coll_if.req_reg_valid = 16'h0001;
    @(posedge clk); #1;
    clearReq();
    checkOutput("rst_reissue_rdv", 64'(coll_if.resp_data_valid), 64'b1000);
    checkData("rst_reissue_data", coll_if.resp_data[3*DATA_W +: DATA_W], pattern(2, 5));

    // Round-robin pointers restart at slot 0 after reset.
    $display("[TB] sequence: pointer reset");
    @(negedge clk);
    coll_if.req_valid = 1'b1; coll_if.req_entry_valid = 4'b0110;
    coll_if.req_reg_num[4*5 +: 5] = 5'd1; coll_if.req_reg_num[8*5 +: 5] = 5'd1;
    coll_if.req_reg_valid = 16'h0110;
    @(posedge clk); #1;
    checkOutput("rr_first_rdv", 64'(coll_if.resp_data_valid), 64'b0010);
    checkOutput("rr_first_coll", 64'(coll_if.resp_coll_index[3:2]), 64'd1);
    coll_if.req_reg_valid[4] = 1'b0;
    @(posedge clk); #1;
    checkOutput("rr_second_coll", 64'(coll_if.resp_coll_index[3:2]), 64'd2);
    clearReq();
    @(posedge clk); #1;
    checkOutput("rr_idle_rdv", 64'(coll_if.resp_data_valid), 64'd0);
`ifdef GELATO_RF_ARB_STATS_EN
    checkOutput("rr_conflict_count", 64'(conflict_count), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
